uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler that shares one UART_TX instance among NUM_REQ byte producers.
//  Accepts one byte at a time via a valid/ready handshake and launches it with a 1-cycle i_TX_DV pulse.
//  Waits for TX completion, optionally inserts an idle guard gap, then re-arbitrates.
//  A watchdog recovers the block if the transmitter never reports done.
//  Sits between the requesters and UART_TX: o_TX_DV/o_TX_Byte drive the TX inputs; i_TX_Active/i_TX_Done come from the TX outputs.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  CLKS_PER_BIT  217  UART bit period in clocks; must match UART_TX
//  GAP_CLKS      2    idle clocks inserted after each byte (0 = none)
//  TIMEOUT_CLKS  12*CLKS_PER_BIT  max clocks from o_TX_DV to i_TX_Done before abort
// PORTS
//  i_Clock      in   1              system clock, all logic on rising edge
//  i_Rst_L      in   1              async active-low reset
//  i_Req_Valid  in   NUM_REQ        per-requester byte valid; held until ready
//  i_Req_Byte   in   8*NUM_REQ      requester k byte at [8k+7:8k]
//  o_Req_Ready  out  NUM_REQ        one-hot accept pulse; byte captured this cycle
//  o_Grant_Id   out  clog2(NUM_REQ) index of requester whose byte is in flight
//  o_Busy       out  1              high in any state other than IDLE
//  o_Timeout    out  1              1-cycle pulse when watchdog aborts a byte
//  o_TX_DV      out  1              to UART_TX i_TX_DV, 1-cycle launch pulse
//  o_TX_Byte    out  8              to UART_TX i_TX_Byte, stable from launch to done
//  i_TX_Active  in   1              from UART_TX o_TX_Active
//  i_TX_Done    in   1              from UART_TX o_TX_Done (1-cycle pulse)
// BEHAVIOUR
//  Reset (async, i_Rst_L=0): state=FLUSH; o_Req_Ready=0, o_Grant_Id=0, o_Busy=1, o_Timeout=0,
//   o_TX_DV=0, o_TX_Byte=0, timers=0, RR pointer=NUM_REQ-1 (so requester 0 has first priority).
//  FSM states: FLUSH, IDLE, LAUNCH, WAIT_DONE, GAP.
//  FLUSH: UART_TX has no reset, so it may still be sending. Stay in FLUSH while i_TX_Active=1; go to IDLE when it is 0.
//  IDLE: o_Busy=0. If any i_Req_Valid is set, the winner is the first valid index found
//   scanning upward (wrapping) from RR pointer+1.
//   - o_Req_Ready[winner]=1 combinationally in the same cycle.
//   - On that edge: capture the byte into o_TX_Byte, set o_Grant_Id=winner, set RR pointer=winner, go to LAUNCH.
//  LAUNCH: o_TX_DV=1 for exactly this one cycle; clear the watchdog; go to WAIT_DONE.
//   Latency: valid seen in IDLE at cycle n -> ready at n -> o_TX_DV at n+1.
//  WAIT_DONE: o_TX_Byte held stable; the watchdog counts up each cycle.
//   - i_TX_Done=1 -> GAP if GAP_CLKS>0, else IDLE.
//   - Watchdog reaching TIMEOUT_CLKS-1 with no done -> pulse o_Timeout, then go to FLUSH.
//   - If i_TX_Done and the timeout hit occur in the same cycle, done wins and there is no timeout pulse.
//  GAP: count GAP_CLKS cycles, then go to IDLE. No grants are issued during GAP.
//  o_Req_Ready is 0 in every state except IDLE. At most one ready bit is set at any time.
//  A requester dropping valid before ready is legal; no grant is issued and no state changes.
//  Valid on the RR pointer index itself gets lowest priority (fairness): with all requesters valid,
//   grants cycle 0,1,2,3,0,...
//  Counters are sized to hold max(GAP_CLKS, TIMEOUT_CLKS) and never wrap.
// TESTING (with UART_TX, and UART_RX on the line, CLKS_PER_BIT=217, 25 MHz clock)
//  1. Reset, then req0 valid with 8'h3F -> ready[0] in the same cycle; o_TX_DV 1 cycle later;
//     RX receives 8'h3F; o_Busy returns to 0 after done+2 clocks.
//  2. All 4 requesters valid continuously with bytes A0..A3 -> RX order A0,A1,A2,A3,A0;
//     o_Grant_Id follows 0,1,2,3,0.
//  3. Only req2 valid, held continuously -> back-to-back grants to 2 with exactly GAP_CLKS
//     idle clocks between i_TX_Done and the next ready.
//  4. Stub TX with i_TX_Done tied to 0 -> o_Timeout pulse exactly TIMEOUT_CLKS clocks after o_TX_DV;
//     then FLUSH; the next request is served normally.
//  5. Assert i_Rst_L low mid-byte -> all outputs reset immediately;
//     no grant until i_TX_Active falls; after that, req1 8'h55 is received correctly.
//  6. req3 valid for 1 cycle during WAIT_DONE, then dropped -> no ready[3], and no byte is sent for req3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX among NUM_REQ producers; ready is combinational in IDLE, launch pulse one cycle later.
// Backpressure: no ready is given while a byte, its guard gap or a post-reset/abort flush is outstanding.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 217,
   parameter int GAP_CLKS     = 2,
   parameter int TIMEOUT_CLKS = 12*CLKS_PER_BIT
) (
   input  logic                       i_Clock,
   input  logic                       i_Rst_L,
   input  logic [NUM_REQ-1:0]         i_Req_Valid,
   input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
   output logic [NUM_REQ-1:0]         o_Req_Ready,
   output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
   output logic                       o_Busy,
   output logic                       o_Timeout,
   output logic                       o_TX_DV,
   output logic [7:0]                 o_TX_Byte,
   input  logic                       i_TX_Active,
   input  logic                       i_TX_Done
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int SW = IW + 1;
   // A watchdog shorter than one 10-bit frame would abort healthy bytes, so it is floored there.
   localparam int TO_EFF  = (TIMEOUT_CLKS > 10*CLKS_PER_BIT) ? TIMEOUT_CLKS : 10*CLKS_PER_BIT + 1;
   localparam int CNT_MAX = (GAP_CLKS > TO_EFF) ? GAP_CLKS : TO_EFF;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TO_EFF - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_CLKS > 0) ? CW'(GAP_CLKS - 1) : '0;

   typedef enum logic [2:0] {FLUSH, IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] win;
   logic          win_vld;
   logic [SW-1:0] scan;
   logic [CW-1:0] timer;
   logic [7:0]    req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = i_Req_Byte[8*g +: 8];
   end

   // Scan upward from the slot after the last winner so the last winner ends up lowest priority.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      scan    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan = {1'b0, rr_ptr} + SW'(i);
         if (scan >= SW'(NUM_REQ)) begin
            scan = scan - SW'(NUM_REQ);
         end
         if (!win_vld && i_Req_Valid[scan[IW-1:0]]) begin
            win_vld = 1'b1;
            win     = scan[IW-1:0];
         end
      end
   end

   always_comb begin
      o_Req_Ready = '0;
      if (state == IDLE && win_vld) begin
         o_Req_Ready[win] = 1'b1;
      end
   end

   // Done arriving on the final watchdog cycle takes precedence over the abort.
   assign o_Timeout = (state == WAIT_DONE) && (timer == TO_LAST) && !i_TX_Done;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= FLUSH;
         rr_ptr     <= IW'(NUM_REQ - 1);
         o_Grant_Id <= '0;
         o_TX_Byte  <= '0;
         o_TX_DV    <= 1'b0;
         o_Busy     <= 1'b1;
         timer      <= '0;
      end else begin
         o_TX_DV <= 1'b0;
         case (state)
            FLUSH: begin
               if (!i_TX_Active) begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            end
            IDLE: begin
               if (win_vld) begin
                  o_TX_Byte  <= req_bytes[win];
                  o_Grant_Id <= win;
                  rr_ptr     <= win;
                  o_TX_DV    <= 1'b1;
                  o_Busy     <= 1'b1;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (i_TX_Done) begin
                  timer <= '0;
                  if (GAP_CLKS > 0) begin
                     state <= GAP;
                  end else begin
                     state  <= IDLE;
                     o_Busy <= 1'b0;
                  end
               end else if (timer == TO_LAST) begin
                  timer <= '0;
                  state <= FLUSH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            GAP: begin
               if (timer == GAP_LAST) begin
                  timer  <= '0;
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state  <= FLUSH;
               o_Busy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural TX stub, per-cycle reference model check, and directed scenarios.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int CPB = 10;
   localparam int GAP = 2;
   localparam int TO  = 12*CPB;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_byte;
   logic [N-1:0]   req_ready;
   logic [1:0]     grant_id;
   logic           busy, timeout, tx_dv, tx_active, tx_done;
   logic [7:0]     tx_byte;

   uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_Valid(req_valid), .i_Req_Byte(req_byte),
      .o_Req_Ready(req_ready), .o_Grant_Id(grant_id), .o_Busy(busy), .o_Timeout(timeout),
      .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(tx_active), .i_TX_Done(tx_done));

   always #5 clk = ~clk;

   int         n_pass = 0, n_total = 0, cyc = 0, n_to = 0, n_rdy3 = 0;
   int         tx_len = 100;
   bit         done_en = 1'b1;
   logic [7:0] rx[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
   endtask

   function automatic logic [7:0] rx_last();
      return (rx.size() > 0) ? rx[$] : 8'h00;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter stand-in: busy tx_len cycles after the launch pulse, then done (unless disabled).
   initial begin
      logic       dv_s;
      logic [7:0] byte_s, cur;
      int         rem;
      tx_active = 1'b0; tx_done = 1'b0; rem = 0; cur = 8'h00;
      forever begin
         @(negedge clk);
         dv_s = tx_dv; byte_s = tx_byte;
         @(posedge clk); #1;
         tx_done = 1'b0;
         if (dv_s) begin
            tx_active = 1'b1; rem = tx_len - 1; cur = byte_s;
         end else if (tx_active) begin
            rem--;
            if (rem == 0) begin
               tx_active = 1'b0;
               if (done_en) begin
                  tx_done = 1'b1;
                  rx.push_back(cur);
               end
            end
         end
      end
   end

   // Reference model: acceptance window, launch timestamp, guard countdown, flush-until-quiet.
   bit         m_accept, m_drain, m_fire, m_send;
   int         m_gap, m_ptr, m_gid, m_launch;
   logic [7:0] m_byte;

   initial begin
      logic [N-1:0] e_rdy;
      int           w;
      bit           e_to;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_accept = 0; m_drain = 1; m_fire = 0; m_send = 0;
            m_gap = 0; m_ptr = N - 1; m_gid = 0; m_byte = 8'h00; m_launch = 0;
         end
         w = -1;
         if (m_accept)
            for (int j = 1; j <= N; j++)
               if (w < 0 && req_valid[(m_ptr + j) % N]) w = (m_ptr + j) % N;
         e_rdy = '0;
         if (w >= 0) e_rdy[w] = 1'b1;
         e_to = m_send && (cyc - m_launch == TO) && !tx_done;
         chk("ready", req_ready, e_rdy);
         chk("tx_dv", tx_dv, m_fire);
         chk("busy", busy, !m_accept);
         chk("timeout", timeout, e_to);
         chk("grant_id", grant_id, m_gid);
         chk("tx_byte", tx_byte, m_byte);
         if (timeout) n_to++;
         if (req_ready[3]) n_rdy3++;
         if (rst_n) begin
            if (m_drain) begin
               if (!tx_active) begin m_drain = 0; m_accept = 1; end
            end else if (w >= 0) begin
               m_accept = 0; m_fire = 1; m_gid = w; m_byte = req_byte[8*w +: 8];
               m_ptr = w; m_launch = cyc + 1;
            end else if (m_fire) begin
               m_fire = 0; m_send = 1;
            end else if (m_send) begin
               if (tx_done) begin
                  m_send = 0; m_gap = GAP;
                  if (GAP == 0) m_accept = 1;
               end else if (e_to) begin
                  m_send = 0; m_drain = 1;
               end
            end else if (m_gap > 0) begin
               m_gap--;
               if (m_gap == 0) m_accept = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready(input string name, output int at);
      at = -1;
      for (int i = 0; i < 2000 && at < 0; i++) begin
         @(negedge clk);
         if (|req_ready) at = cyc;
      end
      chk({name, "_seen"}, (at >= 0), 1'b1);
   endtask

   task automatic wait_done(input string name, output int at);
      at = -1;
      for (int i = 0; i < 2000 && at < 0; i++) begin
         @(negedge clk);
         if (tx_done) at = cyc;
      end
      chk({name, "_seen"}, (at >= 0), 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < 2000 && seen == 0; i++) begin
         @(negedge clk);
         if (!busy && !tx_active) seen = 1;
      end
      chk({name, "_idle"}, seen, 1);
   endtask

   initial begin
      int r, d, t, base, rx0;
      int exp_ids[5];
      exp_ids = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; req_valid = '0; req_byte = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_ready", req_ready, 0);
      chk("rst_dv", tx_dv, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_byte", tx_byte, 0);
      tick(); rst_n = 1'b1;
      tick(); tick();

      // single byte, latency and guard gap
      req_byte[7:0] = 8'h3F; req_valid = 4'b0001;
      @(negedge clk);
      chk("t1_ready_same_cycle", req_ready, 4'b0001);
      chk("t1_dv_not_yet", tx_dv, 0);
      tick(); req_valid = '0;
      @(negedge clk);
      chk("t1_dv_next", tx_dv, 1);
      chk("t1_byte", tx_byte, 8'h3F);
      wait_done("t1_done", d);
      @(negedge clk); chk("t1_busy_d1", busy, 1);
      @(negedge clk); chk("t1_busy_d2", busy, 1);
      @(negedge clk); chk("t1_busy_d3", busy, 0);
      chk("t1_rx", rx_last(), 8'h3F);

      // all requesters valid after a fresh reset
      tick(); rst_n = 1'b0; tick(); rst_n = 1'b1; tick(); tick();
      rx.delete();
      req_byte = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_ready("t2_ready", r);
         chk("t2_ready_onehot", req_ready, 4'b0001 << exp_ids[k]);
         @(negedge clk);
         chk("t2_grant", grant_id, exp_ids[k]);
      end
      tick(); req_valid = '0;
      wait_done("t2_done", d);
      chk("t2_rx_count", rx.size(), 5);
      if (rx.size() == 5) begin
         chk("t2_rx0", rx[0], 8'hA0); chk("t2_rx1", rx[1], 8'hA1); chk("t2_rx2", rx[2], 8'hA2);
         chk("t2_rx3", rx[3], 8'hA3); chk("t2_rx4", rx[4], 8'hA0);
      end

      // single requester held: guard gap between done and next ready
      wait_idle("t3"); tick();
      req_byte[23:16] = 8'h5A; req_valid = 4'b0100;
      wait_ready("t3_first", r);
      chk("t3_ready", req_ready, 4'b0100);
      for (int g = 0; g < 2; g++) begin
         wait_done("t3_done", d);
         wait_ready("t3_next", r);
         chk("t3_gap_clocks", r - d - 1, 2);
         chk("t3_ready_again", req_ready, 4'b0100);
      end
      tick(); req_valid = '0;
      wait_done("t3_last", d);

      // watchdog abort, then normal service
      wait_idle("t4"); tick();
      done_en = 1'b0; tx_len = 140; base = n_to;
      req_byte[7:0] = 8'hC3; req_valid = 4'b0001;
      wait_ready("t4_ready", r);
      tick(); req_valid = '0;
      t = -1;
      for (int i = 0; i < 400 && t < 0; i++) begin
         @(negedge clk);
         if (timeout) t = cyc;
      end
      chk("t4_timeout_delay", t - (r + 1), 120);
      @(negedge clk);
      chk("t4_busy_flush", busy, 1);
      chk("t4_one_pulse", n_to - base, 1);
      for (int i = 0; i < 400 && tx_active; i++) @(negedge clk);
      tick(); done_en = 1'b1; tx_len = 100;
      req_byte[15:8] = 8'h77; req_valid = 4'b0010;
      wait_ready("t4_after", r);
      chk("t4_after_ready", req_ready, 4'b0010);
      tick(); req_valid = '0;
      wait_done("t4_after_done", d);
      chk("t4_after_rx", rx_last(), 8'h77);

      // done on the very last watchdog cycle wins
      wait_idle("t4b"); tick();
      tx_len = TO; base = n_to;
      req_byte[7:0] = 8'h3C; req_valid = 4'b0001;
      wait_ready("t4b_ready", r);
      tick(); req_valid = '0;
      wait_done("t4b_done", d);
      @(negedge clk);
      chk("t4b_done_delay", d - (r + 1), 120);
      chk("t4b_no_timeout", n_to - base, 0);
      chk("t4b_rx", rx_last(), 8'h3C);
      tx_len = 100;

      // reset in mid-byte
      wait_idle("t5"); tick();
      req_byte[15:8] = 8'h99; req_valid = 4'b0010;
      wait_ready("t5_ready", r);
      tick(); req_valid = '0;
      repeat (30) tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_busy", busy, 1);
      chk("t5_rst_byte", tx_byte, 0);
      chk("t5_rst_grant", grant_id, 0);
      chk("t5_rst_dv", tx_dv, 0);
      repeat (3) tick();
      rst_n = 1'b1; req_byte[15:8] = 8'h55; req_valid = 4'b0010;
      wait_ready("t5_after", r);
      chk("t5_tx_quiet", tx_active, 0);
      chk("t5_after_ready", req_ready, 4'b0010);
      tick(); req_valid = '0;
      wait_done("t5_done", d);
      chk("t5_rx", rx_last(), 8'h55);

      // short-lived valid during a byte is ignored
      wait_idle("t6"); tick();
      req_byte[7:0] = 8'h11; req_valid = 4'b0001;
      wait_ready("t6_ready", r);
      tick(); req_valid = '0;
      repeat (20) tick();
      base = n_rdy3; rx0 = rx.size();
      req_byte[31:24] = 8'hEE; req_valid = 4'b1000;
      tick(); req_valid = '0;
      wait_done("t6_done", d);
      repeat (10) @(negedge clk);
      chk("t6_no_ready3", n_rdy3 - base, 0);
      chk("t6_rx_count", rx.size() - rx0, 1);
      chk("t6_rx", rx_last(), 8'h11);
      chk("t6_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit at cycle %0d: run did not end, expected end", cyc);
      $fatal(1, "time limit");
   end

endmodule
